// File: rtl/addsub_if.sv
// Request/response bundle for addsub_pipe: operand handshake in, result handshake out.
// The unit itself connects through the slave modport.
interface addsub_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             ovfl;
  logic             carry;
  logic             zero;
  logic             neg;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, a, b, op, in_tag, out_ready,
    input  in_ready, out_valid, sum, ovfl, carry, zero, neg, out_tag
  );

  modport slave (
    input  in_valid, a, b, op, in_tag, out_ready,
    output in_ready, out_valid, sum, ovfl, carry, zero, neg, out_tag
  );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract with segmented carry chain, signed saturation and N/Z/V/C flags.
// Stage k resolves one SEG-bit slice; the last stage also forms flags and is the output register.

module addsub_stage #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4,
  parameter int TAG_W = 4,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             v_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] be_i,
  input  logic [WIDTH-1:0] r_i,
  input  logic             cy_i,
  input  logic             sat_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             v_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] be_o,
  output logic [WIDTH-1:0] r_o,
  output logic             cy_o,
  output logic             sat_o,
  output logic [TAG_W-1:0] tag_o
);
  logic             v_q, cy_q, sat_q;
  logic [WIDTH-1:0] a_q, be_q, r_q, r_d;
  logic [TAG_W-1:0] tag_q;
  logic [SEG:0]     seg_sum;

  // Resolve slice K; operands travel whole so every stage shares one port shape.
  always_comb begin
    seg_sum = {1'b0, a_i[K*SEG +: SEG]} + {1'b0, be_i[K*SEG +: SEG]} + {{SEG{1'b0}}, cy_i};
    r_d     = r_i;
    r_d[K*SEG +: SEG] = seg_sum[SEG-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q   <= 1'b0;
      a_q   <= '0;
      be_q  <= '0;
      r_q   <= '0;
      cy_q  <= 1'b0;
      sat_q <= 1'b0;
      tag_q <= '0;
    end else if (adv) begin
      v_q   <= v_i;
      a_q   <= a_i;
      be_q  <= be_i;
      r_q   <= r_d;
      cy_q  <= seg_sum[SEG];
      sat_q <= sat_i;
      tag_q <= tag_i;
    end
  end

  assign v_o   = v_q;
  assign a_o   = a_q;
  assign be_o  = be_q;
  assign r_o   = r_q;
  assign cy_o  = cy_q;
  assign sat_o = sat_q;
  assign tag_o = tag_q;
endmodule

module addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4,
  parameter int TAG_W = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  addsub_if.slave  bus
);
  localparam int L   = WIDTH / SEG;
  localparam int MSB = WIDTH - 1;
  localparam int TOP = (L - 1) * SEG;

  // Index k holds the state entering the stage that resolves slice k; index 0 is the request.
  logic             v_s   [0:L-1];
  logic [WIDTH-1:0] a_s   [0:L-1];
  logic [WIDTH-1:0] be_s  [0:L-1];
  logic [WIDTH-1:0] r_s   [0:L-1];
  logic             cy_s  [0:L-1];
  logic             sat_s [0:L-1];
  logic [TAG_W-1:0] tag_s [0:L-1];

  logic             adv;
  logic             out_valid_q, ovfl_q, carry_q, zero_q, neg_q;
  logic [WIDTH-1:0] sum_q;
  logic [TAG_W-1:0] out_tag_q;

  // One enable for the whole pipe: bubbles shift too, so the unit stalls only on a held result.
  assign adv          = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = adv;

  assign v_s[0]   = bus.in_valid;
  assign a_s[0]   = bus.a;
  assign be_s[0]  = bus.op[0] ? ~bus.b : bus.b;
  assign r_s[0]   = '0;
  assign cy_s[0]  = bus.op[0];
  assign sat_s[0] = bus.op[1];
  assign tag_s[0] = bus.in_tag;

  for (genvar k = 1; k < L; k++) begin : g_stg
    addsub_stage #(
      .WIDTH (WIDTH),
      .SEG   (SEG),
      .TAG_W (TAG_W),
      .K     (k - 1)
    ) u_stg (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (adv),
      .v_i   (v_s[k-1]),
      .a_i   (a_s[k-1]),
      .be_i  (be_s[k-1]),
      .r_i   (r_s[k-1]),
      .cy_i  (cy_s[k-1]),
      .sat_i (sat_s[k-1]),
      .tag_i (tag_s[k-1]),
      .v_o   (v_s[k]),
      .a_o   (a_s[k]),
      .be_o  (be_s[k]),
      .r_o   (r_s[k]),
      .cy_o  (cy_s[k]),
      .sat_o (sat_s[k]),
      .tag_o (tag_s[k])
    );
  end

  logic [SEG:0]     fin_seg;
  logic [WIDTH-1:0] raw_d, sum_d;
  logic             ovfl_d, carry_d, zero_d, neg_d;

  always_comb begin
    fin_seg = {1'b0, a_s[L-1][TOP +: SEG]} + {1'b0, be_s[L-1][TOP +: SEG]}
            + {{SEG{1'b0}}, cy_s[L-1]};
    raw_d   = r_s[L-1];
    raw_d[TOP +: SEG] = fin_seg[SEG-1:0];
    carry_d = fin_seg[SEG];
    ovfl_d  = (a_s[L-1][MSB] == be_s[L-1][MSB]) & (raw_d[MSB] != a_s[L-1][MSB]);
    sum_d   = raw_d;
    // On overflow the true result has the sign of A, so clamp toward that end of the range.
    if (sat_s[L-1] && ovfl_d)
      sum_d = a_s[L-1][MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
    zero_d  = ~|sum_d;
    neg_d   = sum_d[MSB];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      ovfl_q      <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      out_tag_q   <= '0;
    end else if (adv) begin
      out_valid_q <= v_s[L-1];
      sum_q       <= sum_d;
      ovfl_q      <= ovfl_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      out_tag_q   <= tag_s[L-1];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.ovfl      = ovfl_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.out_tag   = out_tag_q;
endmodule
